// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: sizes, op codes, FSM states.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_CNT_W = 6;

  // MDUOp encoding; the two top codes are NOPs and leave the unit untouched
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Controller <-> MDU request/response bundle; HI/LO are exported for MFHI/MFLO.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [2:0]       MDUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, MDUOp, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, MDUOp, A, B,
    output busy, done, HI, LO
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used to restore result signs.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res_c
);

  // Negate when the result must be negative, pass through otherwise
  assign res_c = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Magnitudes are processed unsigned one bit per cycle; signs are restored in FIX.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // MUL: full product accumulator; DIV: low half shifts dividend out / quotient in
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // multiplicand magnitude for MUL, divisor magnitude for DIV
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_q, neg_d;
  logic             sgn_a_q, sgn_a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mdu_op_e          op_c;
  logic             signed_op_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_shift_c;
  logic [WIDTH:0]   div_diff_c;
  logic [W2-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  // Operand decode and magnitudes; 0x80000000 maps onto itself as unsigned
  assign op_c        = mdu_op_e'(bus.MDUOp);
  assign signed_op_c = (op_c == OP_MULT) || (op_c == OP_DIV);
  assign a_neg_c     = signed_op_c & bus.A[WIDTH-1];
  assign b_neg_c     = signed_op_c & bus.B[WIDTH-1];
  assign a_abs_c     = a_neg_c ? (~bus.A + WIDTH'(1)) : bus.A;
  assign b_abs_c     = b_neg_c ? (~bus.B + WIDTH'(1)) : bus.B;

  // One shift-add step: add multiplicand to the top half when the LSB is set
  assign mul_sum_c   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring-division step: borrow out of the trial subtract means restore
  assign div_shift_c = {rem_q, acc_q[WIDTH-1]};
  assign div_diff_c  = div_shift_c - {1'b0, opnd_q};

  mdu_sign_fix #(.W(W2)) u_fix_prod (
    .val   (acc_q),
    .neg   (neg_q),
    .res_c (prod_fix_c)
  );

  mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
    .val   (acc_q[WIDTH-1:0]),
    .neg   (neg_q),
    .res_c (quo_fix_c)
  );

  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val   (rem_q),
    .neg   (sgn_a_q),
    .res_c (rem_fix_c)
  );

  // Next-state, datapath and output decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    sgn_a_d  = sgn_a_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (op_c)
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            OP_MULT, OP_MULTU: begin
              acc_d    = {WIDTH'(0), b_abs_c};
              opnd_d   = a_abs_c;
              cnt_d    = CNT_W'(WIDTH);
              is_mul_d = 1'b1;
              neg_d    = a_neg_c ^ b_neg_c;
              sgn_a_d  = a_neg_c;
              state_d  = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              is_mul_d = 1'b0;
              if (bus.B == '0) begin
                // divide by zero: skip iteration, FIX writes HI=A, LO=all ones
                rem_d   = bus.A;
                acc_d   = {WIDTH'(0), {WIDTH{1'b1}}};
                cnt_d   = '0;
                neg_d   = 1'b0;
                sgn_a_d = 1'b0;
                state_d = ST_FIX;
              end else begin
                rem_d   = '0;
                acc_d   = {WIDTH'(0), a_abs_c};
                opnd_d  = b_abs_c;
                cnt_d   = CNT_W'(WIDTH);
                neg_d   = a_neg_c ^ b_neg_c;
                sgn_a_d = a_neg_c;
                state_d = ST_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      ST_MUL: begin
        acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_DIV: begin
        if (div_diff_c[WIDTH]) begin
          rem_d = {rem_q[WIDTH-2:0], acc_q[WIDTH-1]};
        end else begin
          rem_d = div_diff_c[WIDTH-1:0];
        end
        acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff_c[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        hi_d    = is_mul_q ? prod_fix_c[W2-1:WIDTH] : rem_fix_c;
        lo_d    = is_mul_q ? prod_fix_c[WIDTH-1:0]  : quo_fix_c;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIX);
  end

  // State, datapath and registered outputs; reset aborts with no HI/LO update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      sgn_a_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      sgn_a_q  <= sgn_a_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: cycle-level reference model plus directed literal checks.
module tb_mdu;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // {HI, LO} the architecture requires for a MULT/MULTU/DIV/DIVU
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q, rr;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (op == 3'd2) begin
          q  = sa / sb;
          rr = sa % sb;
        end else begin
          q  = longint'(ua / ub);
          rr = longint'(ua % ub);
        end
        return {rr[31:0], q[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Reference model: busy cycles left, architectural HI/LO, pending result
  int          m_left = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  logic [63:0] m_r;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.start) begin
      case (bus.MDUOp)
        3'd4: m_hi = bus.A;
        3'd5: m_lo = bus.A;
        3'd0, 3'd1, 3'd2, 3'd3: begin
          m_r    = ref_result(bus.MDUOp, bus.A, bus.B);
          p_hi   = m_r[63:32];
          p_lo   = m_r[31:0];
          m_left = (bus.MDUOp[1] && bus.B == 32'd0) ? 1 : W + 1;
        end
        default: ;
      endcase
    end
  end

  // Every cycle out of reset, DUT outputs must equal the model
  always @(negedge clk) begin
    if (rst) begin
      check("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
      check("cyc_done", 64'(bus.done), 64'(m_left == 1));
      check("cyc_hi", 64'(bus.HI), 64'(m_hi));
      check("cyc_lo", 64'(bus.LO), 64'(m_lo));
    end
  end

  // Issue one iterative op, measure done latency, check the result afterwards
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] ehi,
                       input logic [31:0] elo, input bit interfere);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
      if (interfere && n == 5) begin
        bus.start = 1'b1;
        bus.MDUOp = 3'd0;
        bus.A     = a ^ 32'h0000FFFF;
      end else if (interfere && n == 6) begin
        bus.MDUOp = 3'd4;
        bus.A     = 32'h00000055;
      end else if (interfere && n == 7) begin
        bus.start = 1'b0;
      end
    end
    check({name, "_lat"}, 64'(n), 64'(exp_lat));
    @(negedge clk);
    check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    check({name, "_hi"}, 64'(bus.HI), 64'(ehi));
    check({name, "_lo"}, 64'(bus.LO), 64'(elo));
  endtask

  logic [31:0] ra, rb;
  logic [2:0]  rop;
  logic [63:0] rr;

  initial begin
    bus.start = 1'b0;
    bus.MDUOp = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // MTHI then MTLO back to back
    bus.start = 1'b1;
    bus.MDUOp = 3'd4;
    bus.A     = 32'hDEADBEEF;
    @(negedge clk);
    check("mthi_hi", 64'(bus.HI), 64'hDEADBEEF);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    bus.MDUOp = 3'd5;
    bus.A     = 32'd5;
    @(negedge clk);
    check("mtlo_lo", 64'(bus.LO), 64'd5);
    check("mtlo_hi", 64'(bus.HI), 64'hDEADBEEF);
    check("mtlo_done", 64'(bus.done), 64'd0);

    // NOP codes are ignored
    bus.MDUOp = 3'd6;
    bus.A     = 32'h11111111;
    @(negedge clk);
    bus.MDUOp = 3'd7;
    @(negedge clk);
    bus.start = 1'b0;
    check("nop_hi", 64'(bus.HI), 64'hDEADBEEF);
    check("nop_lo", 64'(bus.LO), 64'd5);
    check("nop_busy", 64'(bus.busy), 64'd0);

    do_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    do_op("mult_min", 3'd0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b0);
    do_op("mult_busy_start", 3'd0, 32'd3, 32'd5, 33, 32'd0, 32'd15, 1'b1);
    do_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, 1'b0);
    do_op("divu", 3'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    do_op("divu_zero", 3'd3, 32'h00001234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, 1'b0);
    do_op("div_zero", 3'd2, 32'hFFFFFF00, 32'd0, 1, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b0);
    do_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 1'b0);

    // A few extra operand patterns scored by the model
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 2) ? 32'd0 : $urandom;
      if (i == 4) rb = rb >> 20;
      rr  = ref_result(rop, ra, rb);
      do_op("mixed", rop, ra, rb, (rop[1] && rb == 32'd0) ? 1 : 33, rr[63:32], rr[31:0], 1'b0);
    end

    // Asynchronous reset in cycle 10 of a MULT aborts it
    @(negedge clk);
    bus.start = 1'b1;
    bus.MDUOp = 3'd0;
    bus.A     = 32'd1000;
    bus.B     = 32'd1000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi", 64'(bus.HI), 64'd0);
    check("abort_lo", 64'(bus.LO), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 64'(bus.busy), 64'd0);
    do_op("after_rst", 3'd1, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
